// File: rtl/uart_byte_rx_pkg.sv
// Shared UART definitions: frame geometry, receiver state encoding and bit-vote helper.
package uart_byte_rx_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // 2-of-3 majority used to reject single-sample noise on the line.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample prescaler: one-cycle tick every DIV clocks, realigned by a synchronous restart.
module uart_os_tick #(
    parameter int unsigned DIV = 326
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIV-1; restart forces 0 so the first tick lands DIV cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote per bit.
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_int,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIV_RAW = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;

    localparam logic [3:0] POS_S7    = 4'd7;
    localparam logic [3:0] POS_S8    = 4'd8;
    localparam logic [3:0] POS_S9    = 4'd9;
    localparam logic [3:0] POS_LAST  = 4'(UART_OVERSAMPLE - 1);
    localparam logic [3:0] LAST_DATA = 4'(UART_DATA_BITS);

    logic                      sync1;
    logic                      rxs;
    logic                      armed;
    uart_state_e               state;
    logic [3:0]                pos;
    logic [3:0]                bit_cnt;
    logic                      samp7;
    logic                      samp8;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      tick;
    logic                      start_det;
    logic                      decide;
    logic                      bit_val;

    // Two-flop synchronizer; idles high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rs232_rx;
            rxs   <= sync1;
        end
    end

    assign start_det = (state == ST_IDLE) && armed && !rxs;
    assign decide    = tick && (pos == POS_S9);
    assign bit_val   = maj3(samp7, samp8, rxs);

    uart_os_tick #(
        .DIV(DIV)
    ) u_os_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(start_det),
        .tick   (tick)
    );

    // Receive FSM with bit/position counters and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            armed     <= 1'b0;
            pos       <= '0;
            bit_cnt   <= '0;
            samp7     <= 1'b0;
            samp8     <= 1'b0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_int    <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_int    <= 1'b0;
            frame_err <= 1'b0;
            // A frame error below overrides this and disarms until the line is seen high.
            if (rxs) begin
                armed <= 1'b1;
            end
            if ((state != ST_IDLE) && tick) begin
                pos <= pos + 4'd1;
                if (pos == POS_LAST) begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (pos == POS_S7) begin
                    samp7 <= rxs;
                end
                if (pos == POS_S8) begin
                    samp8 <= rxs;
                end
            end
            unique case (state)
                ST_IDLE: begin
                    if (start_det) begin
                        state   <= ST_START;
                        pos     <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (decide) begin
                        if (bit_val) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        shreg <= {bit_val, shreg[UART_DATA_BITS-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (decide) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (bit_val) begin
                            rx_data <= shreg;
                            rx_int  <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            armed     <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
